bus_master_if: RTL and testbench

BUS_MASTER_IF -- requirements
Module: bus_master_if

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_timeout_cnt.sv | 25 ++
 rtl/bus_master_if.sv | 122 ++++++++++++
 tb/tb_bus_master_if.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus master definitions: widths, FSM state encoding, timeout limit.
// Pure definitions, no logic; imported by the bus master and its timeout counter.
// No flow control of its own.
package bus_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  localparam int          TMO_W              = 8;
  localparam int unsigned BUS_TIMEOUT_CYCLES = 255;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUS_TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_STALL  = 2'd3;

  // Core request captured when the access strobe is accepted.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
  } req_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts ACCESS cycles; expired flags the last allowed cycle without slave ready.
// Combinational expired, counter clears on the edge after run drops.
// No backpressure; saturates at the limit.
module bus_timeout_cnt
  import bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (cnt != TMO_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == TMO_LAST);

endmodule

// File: rtl/bus_master_if.sv
// Core-to-bus master: arbitrates, issues one bus_as_ pulse per access, returns read data.
// Latency 3 cycles as_ to rd_data with immediate grant and zero-wait slave; optional BUS_MASTER_IF_TIMEOUT_EN.
// Backpressure via combinational busy; flush aborts only before grant.
module bus_master_if
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  logic [1:0] state;
  req_t       req;
  logic       tmo;

`ifdef BUS_MASTER_IF_TIMEOUT_EN
  logic tmo_run;
  assign tmo_run = (state == ST_ACCESS);

  bus_timeout_cnt u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .run     (tmo_run),
    .expired (tmo)
  );

  // Slave ready on the final cycle still wins over the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= tmo && bus_rdy_;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      req         <= '0;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_data     <= '0;
    end else begin
      bus_as_ <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!as_ && !flush) begin
            req      <= '{addr: addr, rw: rw, wr_data: wr_data};
            bus_req_ <= 1'b0;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush) begin
            bus_req_ <= 1'b1;
            state    <= ST_IDLE;
          end else if (!bus_grnt_) begin
            bus_addr    <= req.addr;
            bus_rw      <= req.rw;
            bus_wr_data <= req.wr_data;
            bus_as_     <= 1'b0;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Flush is deliberately ignored here: a started access always completes.
          if (!bus_rdy_) begin
            bus_req_ <= 1'b1;
            if (bus_rw) begin
              rd_data <= bus_rd_data;
            end
            state <= stall ? ST_STALL : ST_IDLE;
          end else if (tmo) begin
            bus_req_ <= 1'b1;
            rd_data  <= '0;
            state    <= stall ? ST_STALL : ST_IDLE;
          end
        end
        ST_STALL: begin
          if (!stall) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      ST_IDLE:   busy = !as_ && !flush;
      ST_REQ:    busy = 1'b1;
      ST_ACCESS: busy = bus_rdy_;
      default:   busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: flag-based transaction model checked every cycle,
// plus hand-computed literal expectations queued from the stimulus thread.
module tb_bus_master_if;

`ifdef BUS_MASTER_IF_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, flush, as_, rw;
  logic [29:0] addr;
  logic [31:0] wr_data, rd_data, bus_wr_data, bus_rd_data;
  logic        busy, err, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [29:0] bus_addr;

  bus_master_if dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .as_(as_), .rw(rw),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .err(err),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  // ---------------- transaction model ----------------
  logic        m_pend, m_live, m_first, m_hold, m_err, m_brw, m_rw, launch;
  logic [29:0] m_baddr, m_a;
  logic [31:0] m_bwd, m_wd, m_rd;
  int          m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = 0; m_live = 0; m_first = 0; m_hold = 0; m_err = 0; m_cnt = 0;
      m_baddr = '0; m_brw = 1; m_bwd = '0; m_rd = '0;
    end else begin
      m_err  = 0;
      launch = 0;
      if (m_live) begin
        if (!bus_rdy_) begin
          m_live = 0; m_pend = 0; m_hold = stall; m_cnt = 0;
          if (m_brw) m_rd = bus_rd_data;
        end else begin
          m_cnt++;
          if (TMO && m_cnt == 255) begin
            m_live = 0; m_pend = 0; m_hold = stall; m_cnt = 0; m_rd = '0; m_err = 1;
          end
        end
      end else if (m_pend) begin
        if (flush) m_pend = 0;
        else if (!bus_grnt_) begin
          m_live = 1; launch = 1; m_baddr = m_a; m_brw = m_rw; m_bwd = m_wd;
        end
      end else if (m_hold) begin
        if (!stall) m_hold = 0;
      end else if (!as_ && !flush) begin
        m_pend = 1; m_a = addr; m_rw = rw; m_wd = wr_data;
      end
      m_first = launch;
    end
  end

  function automatic logic exp_busy();
    if (m_live) return bus_rdy_;
    if (m_pend) return 1'b1;
    if (m_hold) return 1'b0;
    return !as_ && !flush;
  endfunction

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;
  int n_as = 0, n_busy = 0, n_err = 0, n_reqlo = 0;
  bit chk_en = 0;
  string       lit_nm[64];
  int          lit_sel[64];
  logic [31:0] lit_act[64], lit_exp[64];
  int          lit_n = 0, lit_i = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  function automatic logic [31:0] pick(input int sel, input logic [31:0] act);
    case (sel)
      1: return 32'(bus_req_);
      2: return 32'(bus_as_);
      3: return 32'(bus_rw);
      4: return 32'(bus_addr);
      5: return bus_wr_data;
      6: return rd_data;
      7: return 32'(err);
      8: return 32'(busy);
      default: return act;
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus_as_ === 1'b0) n_as++;
    if (busy === 1'b1) n_busy++;
    if (err === 1'b1) n_err++;
    if (bus_req_ === 1'b0 && bus_as_ === 1'b1) n_reqlo++;
    if (chk_en) begin
      while (lit_i < lit_n) begin
        chk(lit_nm[lit_i], pick(lit_sel[lit_i], lit_act[lit_i]), lit_exp[lit_i]);
        lit_i++;
      end
      chk("bus_req_", 32'(bus_req_), 32'(!m_pend));
      chk("bus_as_", 32'(bus_as_), 32'(!m_first));
      chk("bus_rw", 32'(bus_rw), 32'(m_brw));
      chk("bus_addr", 32'(bus_addr), 32'(m_baddr));
      chk("bus_wr_data", bus_wr_data, m_bwd);
      chk("rd_data", rd_data, m_rd);
      chk("err", 32'(err), 32'(m_err));
      chk("busy", 32'(busy), 32'(exp_busy()));
    end
  end

  // Literal expectation, evaluated at the next falling edge (sel 0 uses act as given).
  task automatic lit(input string nm, input int sel, input logic [31:0] act, input logic [31:0] exp);
    lit_nm[lit_n] = nm; lit_sel[lit_n] = sel; lit_act[lit_n] = act; lit_exp[lit_n] = exp;
    lit_n++;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int b_as, b_busy, b_err, b_rq;

  initial begin
    reset = 1; stall = 0; flush = 0; as_ = 1; rw = 1; addr = '0; wr_data = '0;
    bus_grnt_ = 1; bus_rd_data = '0; bus_rdy_ = 1;
    tick();
    chk_en = 1;
    tick();
    lit("rst_bus_req_", 1, 0, 1); lit("rst_bus_rw", 3, 0, 1);
    lit("rst_rd_data", 6, 0, 0);  lit("rst_bus_addr", 4, 0, 0);
    reset = 0;
    tick();

    // Read, immediate grant, slave ready one cycle after bus_as_.
    b_as = n_as; b_busy = n_busy;
    as_ = 0; rw = 1; addr = 30'h0000100; tick();
    as_ = 1; bus_grnt_ = 0; tick();
    tick();
    bus_rdy_ = 0; bus_rd_data = 32'hDEADBEEF; tick();
    bus_rdy_ = 1; bus_grnt_ = 1; tick();
    lit("t1_as_pulses", 0, n_as - b_as, 1);
    lit("t1_busy_cycles", 0, n_busy - b_busy, 3);
    lit("t1_rd_data", 6, 0, 32'hDEADBEEF);
    tick();

    // Write, grant four cycles late; core fields change after acceptance.
    b_rq = n_reqlo;
    as_ = 0; rw = 0; addr = 30'h00002A0; wr_data = 32'h12345678; tick();
    as_ = 1; rw = 1; addr = '0; wr_data = 32'hFFFFFFFF; tick(3);
    bus_grnt_ = 0; tick();
    lit("t2_req_before_as", 0, n_reqlo - b_rq, 4);
    bus_grnt_ = 1; tick(2);
    lit("t2_bus_wr_data", 5, 0, 32'h12345678);
    lit("t2_bus_addr", 4, 0, 32'h2A0);
    bus_rdy_ = 0; bus_rd_data = 32'h11111111; tick();
    bus_rdy_ = 1; tick();
    lit("t2_rd_data_kept", 6, 0, 32'hDEADBEEF);
    tick();

    // Flush: in IDLE blocks the request; in REQ beats a simultaneous grant.
    b_as = n_as;
    as_ = 0; flush = 1; tick();
    lit("t3_idle_flush_req", 1, 0, 1);
    flush = 0; tick();
    flush = 1; bus_grnt_ = 0; as_ = 1; tick();
    lit("t3_flush_req_", 1, 0, 1);
    lit("t3_flush_busy", 8, 0, 0);
    tick();
    lit("t3_no_as_pulse", 0, n_as - b_as, 0);
    flush = 0; bus_grnt_ = 1; tick();

    // Zero-wait read completing under stall at the top address; new as_ ignored while stalled.
    b_as = n_as;
    as_ = 0; rw = 1; addr = 30'h3FFFFFFF; bus_grnt_ = 0; tick();
    as_ = 1; tick();
    bus_rdy_ = 0; bus_rd_data = 32'hA5A5A5A5; stall = 1; tick();
    lit("t4_latency_rd_data", 6, 0, 32'hA5A5A5A5);
    lit("t4_bus_addr_top", 4, 0, 32'h3FFFFFFF);
    bus_rdy_ = 1; as_ = 0; addr = 30'h77; tick();
    lit("t4_stall_busy", 8, 0, 0);
    tick();
    lit("t4_stall_hold", 6, 0, 32'hA5A5A5A5);
    stall = 0; tick();
    lit("t4_no_req_in_stall", 1, 0, 1);
    tick();
    flush = 1; as_ = 1; tick();
    flush = 0; bus_grnt_ = 1; tick();
    lit("t4_as_pulses", 0, n_as - b_as, 1);

    // Slave never ready for 300 cycles.
    as_ = 0; rw = 1; addr = 30'h155; bus_grnt_ = 0; tick();
    as_ = 1; tick();
    bus_grnt_ = 1;
    b_busy = n_busy; b_err = n_err;
    tick(300);
    lit("t5_err_pulses", 0, n_err - b_err, TMO ? 1 : 0);
    lit("t5_busy_cycles", 0, n_busy - b_busy, TMO ? 255 : 300);
    bus_rdy_ = 0; bus_rd_data = 32'h0BADF00D; tick();
    bus_rdy_ = 1; tick();
    lit("t5_rd_data", 6, 0, TMO ? 32'h0 : 32'h0BADF00D);
    tick();

    // Reset in ACCESS, then a normal read.
    as_ = 0; rw = 1; addr = 30'h0ABCDEF; bus_grnt_ = 0; tick();
    as_ = 1; tick();
    reset = 1; tick();
    lit("t6_bus_req_", 1, 0, 1); lit("t6_bus_as_", 2, 0, 1); lit("t6_bus_rw", 3, 0, 1);
    lit("t6_bus_addr", 4, 0, 0); lit("t6_bus_wr_data", 5, 0, 0);
    lit("t6_rd_data", 6, 0, 0);  lit("t6_err", 7, 0, 0);
    reset = 0; b_as = n_as; tick(2);
    lit("t6_no_as_after_rst", 0, n_as - b_as, 0);
    as_ = 0; tick();
    as_ = 1; tick();
    bus_rdy_ = 0; bus_rd_data = 32'h600DCAFE; tick();
    bus_rdy_ = 1; bus_grnt_ = 1; tick();
    lit("t6_rd_data_after", 6, 0, 32'h600DCAFE);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
